pong_ball: RTL and testbench
============================

// Module: pong_ball
// PURPOSE
//  Ball engine for the Pong game; consumes the edge arrays of both player bars.
//  Moves the ball one pixel per axis per PixelClock tick, bounces it off the top/bottom walls and off the bars.
//  Detects missed balls, keeps both scores and runs the serve/over sequence.
//  Provides drawBall to the top-level video mux and the ball edges for display/debug.
// PARAMETERS
//  bSize      10   ball side length, pixels (square ball)
//  sWidth     800  screen width, pixels
//  sHeight    600  screen height, pixels
//  ServeDelay 120  PixelClock ticks the ball is held at centre before each serve
//  ScoreMax   9    score that ends the game (1..15)
// PORTS
//  Clock          in   1      50MHz system clock
//  Reset          in   1      synchronous, active-high reset
//  PixelClock     in   1      movement enable; a "tick" = PixelClock==1 at a Clock edge
//  xPos           in   12     current hCounter
//  yPos           in   12     current vCounter
//  leftBarEdges   in   11x4   left player bar edges: [0]left [1]right [2]top [3]bottom
//  rightBarEdges  in   11x4   right player bar edges, same order
//  drawBall       out  1      1 while (xPos,yPos) lies inside the ball and state!=OVER
//  ballEdges      out  11x4   ball left/right/top/bottom, same order
//  scoreLeft      out  4      left player score
//  scoreRight     out  4      right player score
//  pointLeft      out  1      one-Clock pulse when the left player scores
//  pointRight     out  1      one-Clock pulse when the right player scores
//  gameOver       out  1      1 in state OVER
// BEHAVIOUR
//  Reset (overrides everything in the same cycle, including a tick):
//   - X = (sWidth-bSize)/2, Y = (sHeight-bSize)/2; with defaults this is (395,295).
//   - dirX = right, dirY = up; state = SERVE; serve counter = 0.
//   - Scores = 0; pulses = 0; gameOver = 0.
//  Ball edges: left=X, right=X+bSize-1, top=Y, bottom=Y+bSize-1. All coordinates are 11-bit unsigned.
//  States: SERVE -> PLAY -> (SERVE | OVER); OVER is left only by Reset.
//  SERVE:
//   - Ball is held at centre; the counter increments on each tick.
//   - On the tick where counter==ServeDelay-1: go to PLAY, counter cleared, no movement on that tick.
//  PLAY (each tick):
//   - Vertical: if dirY==up and top<=1, or dirY==down and bottom>=sHeight-2:
//     flip dirY and leave Y unchanged. Otherwise Y moves by +/-1.
//   - Horizontal, left bar: dirX==left, left==leftBar.right+1, and vertical overlap
//     (bottom>=bar.top and top<=bar.bottom): flip dirX and leave X unchanged.
//   - Horizontal, right bar: mirror rule using right+1==rightBar.left.
//   - Otherwise X moves by +/-1.
//   - Wall and bar bounces on the same tick apply independently, so both directions can flip.
//   - Miss: dirX==left and left==0 means the right player scores; dirX==right and right>=sWidth-1 means the left player scores.
//     Miss takes priority over any bar hit.
//  On a point:
//   - Increment the scorer's score. Its point pulse is 1 for exactly one Clock cycle.
//   - Recentre the ball; dirX points toward the player who conceded; dirY is kept; counter = 0.
//   - If the new score == ScoreMax: go to OVER. Otherwise go to SERVE.
//  OVER: ball at centre, drawBall=0, ticks ignored, scores frozen, gameOver=1.
//  Non-tick cycles: no state, position or score change.
//  drawBall, ballEdges and gameOver are combinational from registers/inputs (zero latency). Pulses are registered.
// STRUCTURE
//  pong_pkg (shared):
//   - coord_t = logic[10:0]
//   - EDGE_LEFT=0, EDGE_RIGHT=1, EDGE_TOP=2, EDGE_BOTTOM=3
//   - ball_state_t enum {SERVE, PLAY, OVER}
//  Sub-module pong_score_counter, instantiated twice:
//   - 4-bit counter with inc input; outputs count, a one-cycle pulse, and reached (count==ScoreMax).
//  Collision and miss detection stays inline as combinational logic.
// TESTING
//  1 Reset, ServeDelay=4 -> after 3 ticks ball still at (395,295); 4th tick enters PLAY;
//    next tick gives (396,294).
//  2 Bars far from the ball path; run 294 PLAY ticks -> Y=1; next tick Y stays 1 and dirY=down;
//    the following tick gives Y=2.
//  3 rightBarEdges={770,789,250,349}, ball at X=760 (right=769) moving right with Y within bar span
//    -> next tick X stays 760 and dirX=left; the following tick gives X=759.
//  4 rightBarEdges top/bottom={0,49}, ball at Y~300 moving right -> when right reaches 799:
//    pointLeft high for 1 Clock, scoreLeft 0->1, ball at (395,295), state SERVE, dirX=right.
//  5 ScoreMax=2, two left points -> gameOver=1, drawBall=0 for the full frame, ticks ignored;
//    Reset -> scores 0, SERVE.
//  6 Reset asserted on the same cycle as a PLAY tick -> reset values, no movement applied.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong ball engine.
//   coord_t       : 11-bit unsigned screen coordinate
//   EDGE_*        : index of each edge inside a 4-entry edge array
//   ball_state_t  : serve / play / game-over sequencing states
package pong_pkg;

   typedef logic [10:0] coord_t;

   localparam int EDGE_LEFT   = 0;
   localparam int EDGE_RIGHT  = 1;
   localparam int EDGE_TOP    = 2;
   localparam int EDGE_BOTTOM = 3;

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      PLAY  = 2'd1,
      OVER  = 2'd2
   } ball_state_t;

endpackage

// File: rtl/pong_score_counter.sv
// One player's score.
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   inc_i     : add one point this cycle
//   count_o   : current score
//   pulse_o   : registered one-cycle pulse following an increment
//   reached_o : score equals ScoreMax
module pong_score_counter #(
   parameter int ScoreMax = 9
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inc_i,
   output logic [3:0] count_o,
   output logic       pulse_o,
   output logic       reached_o
);

   logic [3:0] count_q, count_d;
   logic       pulse_q;

   always_comb begin
      count_d = count_q;
      if (inc_i) count_d = count_q + 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 4'd0;
         pulse_q <= 1'b0;
      end else begin
         count_q <= count_d;
         pulse_q <= inc_i;
      end
   end

   assign count_o   = count_q;
   assign pulse_o   = pulse_q;
   assign reached_o = (count_q == 4'(ScoreMax));

endmodule

// File: rtl/pong_ball.sv
// Pong ball engine: moves the ball one pixel per axis per PixelClock tick,
// bounces it off the top/bottom walls and both bars, detects misses, keeps
// both scores and sequences serve / play / game over.
//   Clock, Reset           : system clock, synchronous active-high reset
//   PixelClock             : movement enable (tick = high at a Clock edge)
//   xPos, yPos             : current raster position
//   leftBarEdges           : left bar  [left,right,top,bottom]
//   rightBarEdges          : right bar [left,right,top,bottom]
//   drawBall               : raster position inside ball (never in OVER)
//   ballEdges              : ball [left,right,top,bottom]
//   scoreLeft, scoreRight  : player scores
//   pointLeft, pointRight  : one-cycle pulse when that player scores
//   gameOver               : game finished, waiting for Reset
module pong_ball
   import pong_pkg::*;
#(
   parameter int bSize      = 10,
   parameter int sWidth     = 800,
   parameter int sHeight    = 600,
   parameter int ServeDelay = 120,
   parameter int ScoreMax   = 9
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             PixelClock,
   input  logic [11:0]      xPos,
   input  logic [11:0]      yPos,
   input  coord_t [3:0]     leftBarEdges,
   input  coord_t [3:0]     rightBarEdges,
   output logic             drawBall,
   output coord_t [3:0]     ballEdges,
   output logic [3:0]       scoreLeft,
   output logic [3:0]       scoreRight,
   output logic             pointLeft,
   output logic             pointRight,
   output logic             gameOver
);

   localparam coord_t      X_C      = coord_t'((sWidth - bSize) / 2);
   localparam coord_t      Y_C      = coord_t'((sHeight - bSize) / 2);
   localparam coord_t      B_M1     = coord_t'(bSize - 1);
   localparam coord_t      X_MAX    = coord_t'(sWidth - 1);
   localparam coord_t      Y_MAX    = coord_t'(sHeight - 2);
   localparam int          CW       = (ServeDelay > 1) ? $clog2(ServeDelay) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ServeDelay - 1);
   localparam logic [3:0]  SC_LAST  = 4'(ScoreMax - 1);

   ball_state_t   state_q;
   coord_t        x_q, y_q, x_d, y_d;
   logic          right_q, down_q, right_d, down_d;
   logic [CW-1:0] cnt_q;

   coord_t b_left, b_right, b_top, b_bot, b_right_p1, lbar_p1;
   logic   ovl_l, ovl_r, hit_l, hit_r, wall, miss_l, miss_r;
   logic   play_tick, reached_l, reached_r;

   always_comb begin
      b_left     = x_q;
      b_right    = x_q + B_M1;
      b_top      = y_q;
      b_bot      = y_q + B_M1;
      b_right_p1 = b_right + coord_t'(1);
      lbar_p1    = leftBarEdges[EDGE_RIGHT] + coord_t'(1);

      ovl_l = (b_bot >= leftBarEdges[EDGE_TOP])  && (b_top <= leftBarEdges[EDGE_BOTTOM]);
      ovl_r = (b_bot >= rightBarEdges[EDGE_TOP]) && (b_top <= rightBarEdges[EDGE_BOTTOM]);
      hit_l = !right_q && (b_left == lbar_p1) && ovl_l;
      hit_r =  right_q && (b_right_p1 == rightBarEdges[EDGE_LEFT]) && ovl_r;
      wall  = (!down_q && (b_top <= coord_t'(1))) || (down_q && (b_bot >= Y_MAX));

      // miss_r: ball left the right side, so the left player scores
      miss_r =  right_q && (b_right >= X_MAX);
      miss_l = !right_q && (b_left == coord_t'(0));

      // A bounce holds the coordinate for this tick and only flips direction
      down_d  = wall ? !down_q : down_q;
      y_d     = wall ? y_q : (down_q ? y_q + coord_t'(1) : y_q - coord_t'(1));
      right_d = (hit_l || hit_r) ? !right_q : right_q;
      x_d     = (hit_l || hit_r) ? x_q : (right_q ? x_q + coord_t'(1) : x_q - coord_t'(1));
   end

   assign play_tick = PixelClock && (state_q == PLAY);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= SERVE;
         x_q     <= X_C;
         y_q     <= Y_C;
         right_q <= 1'b1;
         down_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (PixelClock) begin
         case (state_q)
            SERVE: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= PLAY;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            PLAY: begin
               if (miss_r || miss_l) begin
                  x_q     <= X_C;
                  y_q     <= Y_C;
                  right_q <= miss_r;  // serve toward the player who conceded
                  cnt_q   <= '0;
                  if (miss_r ? (scoreLeft == SC_LAST) : (scoreRight == SC_LAST))
                     state_q <= OVER;
                  else
                     state_q <= SERVE;
               end else begin
                  x_q     <= x_d;
                  y_q     <= y_d;
                  right_q <= right_d;
                  down_q  <= down_d;
               end
            end
            OVER:    ;
            default: state_q <= SERVE;
         endcase
      end
   end

   pong_score_counter #(.ScoreMax(ScoreMax)) u_score_left (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .inc_i     (play_tick && miss_r && !reached_l),
      .count_o   (scoreLeft),
      .pulse_o   (pointLeft),
      .reached_o (reached_l)
   );

   pong_score_counter #(.ScoreMax(ScoreMax)) u_score_right (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .inc_i     (play_tick && miss_l && !reached_r),
      .count_o   (scoreRight),
      .pulse_o   (pointRight),
      .reached_o (reached_r)
   );

   assign ballEdges[EDGE_LEFT]   = b_left;
   assign ballEdges[EDGE_RIGHT]  = b_right;
   assign ballEdges[EDGE_TOP]    = b_top;
   assign ballEdges[EDGE_BOTTOM] = b_bot;

   assign gameOver = (state_q == OVER);
   assign drawBall = (state_q != OVER) &&
                     (xPos >= {1'b0, b_left}) && (xPos <= {1'b0, b_right}) &&
                     (yPos >= {1'b0, b_top})  && (yPos <= {1'b0, b_bot});

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball with ServeDelay=4 and ScoreMax=2.
module tb_pong_ball;
   import pong_pkg::*;

   logic             Clock = 1'b0;
   logic             Reset, PixelClock;
   logic [11:0]      xPos, yPos;
   logic [3:0][10:0] lbar, rbar;
   logic             drawBall;
   logic [3:0][10:0] ballEdges;
   logic [3:0]       scoreLeft, scoreRight;
   logic             pointLeft, pointRight, gameOver;

   int checks = 0;
   int errors = 0;
   int drawn;

   always #5 Clock = ~Clock;

   pong_ball #(.ServeDelay(4), .ScoreMax(2)) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .PixelClock    (PixelClock),
      .xPos          (xPos),
      .yPos          (yPos),
      .leftBarEdges  (lbar),
      .rightBarEdges (rbar),
      .drawBall      (drawBall),
      .ballEdges     (ballEdges),
      .scoreLeft     (scoreLeft),
      .scoreRight    (scoreRight),
      .pointLeft     (pointLeft),
      .pointRight    (pointRight),
      .gameOver      (gameOver)
   );

   function automatic logic [3:0][10:0] mk_bar(input int l, input int r, input int t, input int b);
      logic [3:0][10:0] e;
      e[EDGE_LEFT]   = 11'(l);
      e[EDGE_RIGHT]  = 11'(r);
      e[EDGE_TOP]    = 11'(t);
      e[EDGE_BOTTOM] = 11'(b);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ball(input string tag, input int ex, input int ey);
      chk({tag, " x"}, 32'(ballEdges[EDGE_LEFT]), ex);
      chk({tag, " y"}, 32'(ballEdges[EDGE_TOP]), ey);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         PixelClock = 1'b1;
         @(posedge Clock); #1;
         PixelClock = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clock); #1;
      end
   endtask

   // count drawn pixels over a 20x20 window around the centred ball
   task automatic sweep(output int cnt);
      cnt = 0;
      for (int yy = 290; yy < 310; yy++)
         for (int xx = 390; xx < 410; xx++) begin
            xPos = 12'(xx); yPos = 12'(yy); #1;
            if (drawBall) cnt++;
         end
   endtask

   initial begin
      Reset = 1'b1; PixelClock = 1'b0; xPos = '0; yPos = '0;
      lbar = mk_bar(0, 9, 550, 599);
      rbar = mk_bar(770, 789, 550, 599);
      idle(2);
      Reset = 1'b0;

      // reset state
      chk_ball("reset", 395, 295);
      chk("reset right", 32'(ballEdges[EDGE_RIGHT]), 404);
      chk("reset bottom", 32'(ballEdges[EDGE_BOTTOM]), 304);
      chk("reset scoreL", 32'(scoreLeft), 0);
      chk("reset scoreR", 32'(scoreRight), 0);
      chk("reset pulses", 32'({pointLeft, pointRight}), 0);
      chk("reset gameOver", 32'(gameOver), 0);
      sweep(drawn);
      chk("draw area", drawn, 100);
      xPos = 12'd404; yPos = 12'd304; #1;
      chk("draw corner", 32'(drawBall), 1);
      xPos = 12'd405; #1;
      chk("draw outside", 32'(drawBall), 0);

      // serve then first move
      tick(3);  chk_ball("serve 3", 395, 295);
      tick(1);  chk_ball("serve 4", 395, 295);
      tick(1);  chk_ball("play 1", 396, 294);

      // top wall bounce
      tick(293); chk_ball("top reach", 689, 1);
      tick(1);   chk_ball("top bounce", 690, 1);
      tick(1);   chk_ball("after top", 691, 2);
      idle(3);   chk_ball("no tick", 691, 2);

      // reset on a play tick
      Reset = 1'b1; PixelClock = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0; PixelClock = 1'b0;
      chk_ball("reset+tick", 395, 295);
      tick(3); chk_ball("reserve 3", 395, 295);

      // bar bounces: right bar at 510, left bar at 399, then right bar at 770
      lbar = mk_bar(390, 399, 0, 599);
      rbar = mk_bar(510, 529, 0, 599);
      tick(1);   chk_ball("reserve 4", 395, 295);
      tick(105); chk_ball("near rbar", 500, 190);
      tick(1);   chk_ball("rbar hit", 500, 189);
      rbar = mk_bar(770, 789, 250, 349);
      tick(1);   chk_ball("rbar away", 499, 188);
      tick(99);  chk_ball("near lbar", 400, 89);
      tick(1);   chk_ball("lbar hit", 400, 88);
      tick(359); chk_ball("pre 760", 759, 272);
      tick(1);   chk_ball("at 760", 760, 273);
      tick(1);   chk_ball("rbar770 hit", 760, 274);
      tick(1);   chk_ball("rbar770 away", 759, 275);

      // back to the left bar, then out on the right side
      tick(359); chk_ball("lbar again", 400, 545);
      rbar = mk_bar(770, 789, 0, 49);
      tick(1);   chk_ball("lbar hit 2", 400, 544);
      tick(390); chk_ball("edge 799", 790, 154);
      tick(1);
      chk("miss pulseL", 32'(pointLeft), 1);
      chk("miss pulseR", 32'(pointRight), 0);
      chk("miss scoreL", 32'(scoreLeft), 1);
      chk("miss scoreR", 32'(scoreRight), 0);
      chk("miss gameOver", 32'(gameOver), 0);
      chk_ball("miss centre", 395, 295);
      idle(1);
      chk("pulse width", 32'(pointLeft), 0);
      chk("score hold", 32'(scoreLeft), 1);
      tick(4);   chk_ball("serve after pt", 395, 295);
      tick(1);   chk_ball("dir after pt", 396, 294);

      // second left point ends the game
      tick(394); chk_ball("edge 2", 790, 101);
      tick(1);
      chk("final scoreL", 32'(scoreLeft), 2);
      chk("final pulseL", 32'(pointLeft), 1);
      chk("over flag", 32'(gameOver), 1);
      chk_ball("over centre", 395, 295);
      tick(5);
      chk_ball("over frozen", 395, 295);
      chk("over score", 32'(scoreLeft), 2);
      chk("over flag held", 32'(gameOver), 1);
      sweep(drawn);
      chk("over no draw", drawn, 0);

      // reset leaves OVER
      Reset = 1'b1;
      idle(1);
      Reset = 1'b0;
      chk("rst scoreL", 32'(scoreLeft), 0);
      chk("rst gameOver", 32'(gameOver), 0);
      xPos = 12'd400; yPos = 12'd300; #1;
      chk("rst draw", 32'(drawBall), 1);
      tick(3);  chk_ball("rst serve", 395, 295);
      tick(2);  chk_ball("rst play", 396, 294);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
